// File: rtl/key_debounce.sv
// rtl/key_debounce.sv - multi-channel push-button synchroniser and debouncer
//
// Each channel runs the raw active-low pin through a two-flop synchroniser,
// then accepts a new level only after it has differed from the current
// debounced level for DEBOUNCE_CYCLES consecutive clocks.
//
// Parameters:
//   NUM_KEYS        number of independent channels
//   DEBOUNCE_CYCLES required stable time in clk cycles (1 .. 2^24)
//
// Ports:
//   clk          system clock, all registers on rising edge
//   reset_n      synchronous active-low reset
//   key_raw_n    asynchronous active-low button pins (0 = pressed)
//   key_out_n    debounced active-low key level
//   key_press    one-cycle pulse when a channel's debounced level goes 1 -> 0
//   key_release  one-cycle pulse when a channel's debounced level goes 0 -> 1
//                (present only when KEY_DEBOUNCE_RELEASE_EN is defined)
module key_debounce #(
  parameter int NUM_KEYS        = 2,
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic [NUM_KEYS-1:0] key_raw_n,
  output logic [NUM_KEYS-1:0] key_out_n,
  output logic [NUM_KEYS-1:0] key_press
`ifdef KEY_DEBOUNCE_RELEASE_EN
  ,
  output logic [NUM_KEYS-1:0] key_release
`endif
);

  // A single-cycle debounce still needs one counter bit to keep the datapath uniform.
  localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [NUM_KEYS-1:0] sync1;
  logic [NUM_KEYS-1:0] sync2;
  logic [NUM_KEYS-1:0] stable;
  logic [NUM_KEYS-1:0] stable_nxt;
  logic [CNT_W-1:0]    cnt     [NUM_KEYS];
  logic [CNT_W-1:0]    cnt_nxt [NUM_KEYS];

  // Count only while the synchronised input disagrees with the debounced
  // level; any agreement drops the partial count so bounces never add up.
  always_comb begin
    stable_nxt = stable;
    for (int i = 0; i < NUM_KEYS; i++) begin
      cnt_nxt[i] = '0;
      if (sync2[i] != stable[i]) begin
        if (cnt[i] == CNT_MAX) begin
          stable_nxt[i] = sync2[i];
        end else begin
          cnt_nxt[i] = cnt[i] + CNT_W'(1);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      sync1     <= '1;
      sync2     <= '1;
      stable    <= '1;
      key_press <= '0;
      for (int i = 0; i < NUM_KEYS; i++) begin
        cnt[i] <= '0;
      end
    end else begin
      sync1     <= key_raw_n;
      sync2     <= sync1;
      stable    <= stable_nxt;
      key_press <= stable & ~stable_nxt;
      for (int i = 0; i < NUM_KEYS; i++) begin
        cnt[i] <= cnt_nxt[i];
      end
    end
  end

`ifdef KEY_DEBOUNCE_RELEASE_EN
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      key_release <= '0;
    end else begin
      key_release <= ~stable & stable_nxt;
    end
  end
`endif

  assign key_out_n = stable;

endmodule

// File: tb/tb_key_debounce.sv
// tb/tb_key_debounce.sv - directed vector bench for key_debounce
module tb_key_debounce;

  logic       clk;
  logic       reset_n;
  logic [1:0] key_raw_n;
  logic [1:0] key_out_n;
  logic [1:0] key_press;
  logic [1:0] key_release;
  logic [0:0] raw1_n;
  logic [0:0] out1_n;
  logic [0:0] press1;
  logic [0:0] release1;

  int checks = 0;
  int errors = 0;

  key_debounce #(.NUM_KEYS(2), .DEBOUNCE_CYCLES(4)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .key_raw_n (key_raw_n),
    .key_out_n (key_out_n),
    .key_press (key_press)
`ifdef KEY_DEBOUNCE_RELEASE_EN
    ,
    .key_release (key_release)
`endif
  );

  key_debounce #(.NUM_KEYS(1), .DEBOUNCE_CYCLES(1)) dut1 (
    .clk       (clk),
    .reset_n   (reset_n),
    .key_raw_n (raw1_n),
    .key_out_n (out1_n),
    .key_press (press1)
`ifdef KEY_DEBOUNCE_RELEASE_EN
    ,
    .key_release (release1)
`endif
  );

`ifndef KEY_DEBOUNCE_RELEASE_EN
  assign key_release = '0;
  assign release1    = '0;
`endif

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       rst_n;
    logic [1:0] raw;
    logic [1:0] exp_out;
    logic [1:0] exp_press;
    logic [1:0] exp_rel;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic r, input logic [1:0] raw, input logic [1:0] o,
                     input logic [1:0] p, input logic [1:0] rl);
    vec_t v;
    v.rst_n = r; v.raw = raw; v.exp_out = o; v.exp_press = p; v.exp_rel = rl;
    vecs.push_back(v);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check2(input string name, input logic [1:0] act, input logic [1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  // Seven-row press or release of a given raw pattern: the new level lands
  // on the sixth edge after it is driven, with a one-row pulse.
  task automatic add_change(input logic [1:0] raw, input logic [1:0] old_out,
                            input logic [1:0] p, input logic [1:0] rl);
    for (int k = 1; k <= 7; k++) begin
      if (k < 6)       add(1'b1, raw, old_out, 2'b00, 2'b00);
      else if (k == 6) add(1'b1, raw, raw, p, rl);
      else             add(1'b1, raw, raw, 2'b00, 2'b00);
    end
  endtask

  initial begin
    reset_n   = 1'b0;
    key_raw_n = 2'b11;
    raw1_n    = 1'b1;

    add(1'b0, 2'b11, 2'b11, 2'b00, 2'b00);
    add(1'b1, 2'b11, 2'b11, 2'b00, 2'b00);
    // key 0 press and release
    add_change(2'b10, 2'b11, 2'b01, 2'b00);
    add_change(2'b11, 2'b10, 2'b00, 2'b01);
    // bounce on key 0: never qualifies
    for (int k = 0; k < 3; k++) add(1'b1, 2'b10, 2'b11, 2'b00, 2'b00);
    add(1'b1, 2'b11, 2'b11, 2'b00, 2'b00);
    for (int k = 0; k < 3; k++) add(1'b1, 2'b10, 2'b11, 2'b00, 2'b00);
    for (int k = 0; k < 6; k++) add(1'b1, 2'b11, 2'b11, 2'b00, 2'b00);
    // both keys together
    add_change(2'b00, 2'b11, 2'b11, 2'b00);
    add_change(2'b11, 2'b00, 2'b00, 2'b11);

    foreach (vecs[i]) begin
      reset_n   = vecs[i].rst_n;
      key_raw_n = vecs[i].raw;
      tick();
      check2($sformatf("vec%0d key_out_n", i), key_out_n, vecs[i].exp_out);
      check2($sformatf("vec%0d key_press", i), key_press, vecs[i].exp_press);
`ifdef KEY_DEBOUNCE_RELEASE_EN
      check2($sformatf("vec%0d key_release", i), key_release, vecs[i].exp_rel);
`endif
    end

    // Reset mid-count discards progress on key 1
    key_raw_n = 2'b01;
    for (int k = 0; k < 4; k++) tick();
    reset_n = 1'b0;
    tick();
    check2("rst_mid key_out_n", key_out_n, 2'b11);
    check2("rst_mid key_press", key_press, 2'b00);
    reset_n = 1'b1;
    for (int k = 1; k <= 6; k++) begin
      tick();
      check2($sformatf("rst_rel%0d key_out_n", k), key_out_n, (k == 6) ? 2'b01 : 2'b11);
      check2($sformatf("rst_rel%0d key_press", k), key_press, (k == 6) ? 2'b10 : 2'b00);
    end
    key_raw_n = 2'b11;
    for (int k = 0; k < 7; k++) tick();
    check2("rst_after_release key_out_n", key_out_n, 2'b11);

    // Periodic one-cycle glitch on key 1 must never qualify
    for (int c = 0; c < 100; c++) begin
      key_raw_n = (c % 4 == 0) ? 2'b01 : 2'b11;
      tick();
      check2($sformatf("glitch%0d key_out_n", c), key_out_n, 2'b11);
      check2($sformatf("glitch%0d key_press", c), key_press, 2'b00);
    end
    key_raw_n = 2'b11;
    for (int k = 0; k < 4; k++) tick();

    // Single-cycle debounce: change lands on the third edge after driving
    raw1_n = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      tick();
      check2($sformatf("d1_press%0d out", k), {1'b0, out1_n}, (k >= 3) ? 2'b00 : 2'b01);
      check2($sformatf("d1_press%0d pulse", k), {1'b0, press1}, (k == 3) ? 2'b01 : 2'b00);
    end
    raw1_n = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      tick();
      check2($sformatf("d1_rel%0d out", k), {1'b0, out1_n}, (k >= 3) ? 2'b01 : 2'b00);
`ifdef KEY_DEBOUNCE_RELEASE_EN
      check2($sformatf("d1_rel%0d pulse", k), {1'b0, release1}, (k == 3) ? 2'b01 : 2'b00);
`endif
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/key_debounce.md
KEY_DEBOUNCE -- requirements
Module: key_debounce

Interface
REQ-001 The block SHALL provide parameter NUM_KEYS, default 2, the number of independent push-button channels.
REQ-002 The block SHALL provide parameter DEBOUNCE_CYCLES, default 500000, the required stable-input time in clk cycles (10 ms at 50 MHz); legal range is 1 to 2^24.
REQ-003 The block SHALL provide port clk, input, 1 bit, the single system clock; every register is clocked on its rising edge.
REQ-004 The block SHALL provide port reset_n, input, 1 bit, the reset: synchronous and active-low.
REQ-005 The block SHALL provide port key_raw_n, input, NUM_KEYS bits, asynchronous active-low push-button pins (0 = pressed).
REQ-006 The block SHALL provide port key_out_n, output, NUM_KEYS bits, the debounced active-low key level, wired directly to the downstream PIO in_port.
REQ-007 The block SHALL provide port key_press, output, NUM_KEYS bits, a one-cycle active-high pulse per channel on a debounced press.

Function
REQ-008 Each channel SHALL pass key_raw_n through two flip-flops (sync1, then sync2) before any other logic uses it.
REQ-009 Each channel SHALL hold a stable register (driving key_out_n) and a counter cnt of width clog2(DEBOUNCE_CYCLES) bits, minimum 1 bit.
REQ-010 On a clock edge where sync2 equals stable, cnt SHALL be cleared to 0.
REQ-011 On a clock edge where sync2 differs from stable and cnt is below DEBOUNCE_CYCLES-1, cnt SHALL increment by 1.
REQ-012 On a clock edge where sync2 differs from stable and cnt equals DEBOUNCE_CYCLES-1, stable SHALL load sync2 and cnt SHALL clear to 0.
REQ-013 cnt SHALL never exceed DEBOUNCE_CYCLES-1 and SHALL never wrap.
REQ-014 A raw level held for at least DEBOUNCE_CYCLES+2 consecutive sampling edges SHALL appear on key_out_n exactly DEBOUNCE_CYCLES+2 cycles after the first edge that samples it into sync1.
REQ-015 A raw pulse or bounce shorter than DEBOUNCE_CYCLES cycles at sync2 SHALL NOT change key_out_n.
REQ-016 Any return of sync2 to the stable value SHALL restart the count from 0; partial counts SHALL NOT accumulate.
REQ-017 key_press[i] SHALL be high for exactly one cycle, registered, on the same edge that stable[i] changes from 1 to 0.
REQ-018 Channels SHALL be fully independent; simultaneous transitions on several keys SHALL each behave as if alone.
REQ-019 With DEBOUNCE_CYCLES = 1, a change SHALL reach key_out_n 3 cycles after it is sampled into sync1.

Reset
REQ-020 While reset_n is low at a rising clk edge, sync1, sync2 and stable SHALL be set to all ones (released), cnt to 0, and key_press to 0.
REQ-021 Reset asserted mid-count SHALL discard the count; after release, a held-pressed key SHALL need the full DEBOUNCE_CYCLES+2 cycles to appear.
REQ-022 key_out_n SHALL read all ones from the first edge with reset_n low until a qualified change occurs.

Configuration
REQ-023 When macro KEY_DEBOUNCE_RELEASE_EN is defined, the block SHALL add output key_release, NUM_KEYS bits, pulsing high for exactly one cycle when stable[i] changes from 0 to 1; key_release SHALL reset to 0.
REQ-024 When KEY_DEBOUNCE_RELEASE_EN is undefined, the key_release port and its logic SHALL be absent, and all other behaviour SHALL be unchanged.

Verification (DEBOUNCE_CYCLES=4, NUM_KEYS=2)
REQ-025 Scenario: drive key_raw_n=2'b10 at cycle 0 and hold it -> key_out_n=2'b10 at cycle 6, with key_press=2'b01 for that single cycle.
REQ-026 Scenario: bounce key 0 low 3 cycles, high 1 cycle, low 3 cycles, then release -> key_out_n stays 2'b11 and key_press stays 0 throughout.
REQ-027 Scenario: press both keys on the same cycle -> key_out_n goes 2'b11 to 2'b00 in one step, with key_press=2'b11 for one cycle.
REQ-028 Scenario: press key 1, then pulse reset_n low for 1 cycle at count 2 -> key_out_n returns to 2'b11 and is 2'b01 only 6 cycles after reset release.
REQ-029 Scenario: with KEY_DEBOUNCE_RELEASE_EN defined, release key 0 after a debounced press -> key_out_n[0] returns to 1 at 6 cycles, with key_release=2'b01 for one cycle.
REQ-030 Scenario: hold a 1-cycle glitch on key 1 every 4 cycles for 100 cycles -> key_out_n[1] never changes and cnt never exceeds 3.
